// File: rtl/peridot_pfc_uart_pkg.sv
// Shared definitions for the PERIDOT pin-function-controller UART:
// register map, status bit positions and the frame FSM encoding.
package peridot_pfc_uart_pkg;

    localparam int unsigned DIV_W  = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BUS_W  = 32;
    localparam int unsigned FUNC_W = 8;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_DIV  = 2'd2;

    localparam int unsigned STAT_TXREADY = 0;
    localparam int unsigned STAT_RXVALID = 1;
    localparam int unsigned STAT_OVERRUN = 2;
    localparam int unsigned STAT_FERR    = 3;
    localparam int unsigned STAT_RXIE    = 8;
    localparam int unsigned STAT_TXIE    = 9;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/peridot_pfc_uart_rx.sv
// 8N1 receiver: 2-FF synchronizer, start-edge detect with mid-bit glitch
// rejection, LSB-first data capture and stop-bit check.
module peridot_pfc_uart_rx
    import peridot_pfc_uart_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_rxd,
    input  logic [DIV_W-1:0]  i_divider,
    output logic [BYTE_W-1:0] o_rx_byte,
    output logic              o_rx_done,
    output logic              o_rx_ferr
);

    localparam int unsigned HALF_W = DIV_W + 1;

    logic [1:0]        r_sync;
    logic              r_prev;
    uart_state_e       r_state,  w_state_nxt;
    logic [DIV_W-1:0]  r_cnt,    w_cnt_nxt;
    logic [DIV_W-1:0]  r_div,    w_div_nxt;
    logic [2:0]        r_bit,    w_bit_nxt;
    logic [BYTE_W-1:0] r_shift,  w_shift_nxt;
    logic              r_done,   w_done_nxt;
    logic              r_ferr,   w_ferr_nxt;

    logic              w_rxd;
    logic              w_fall;
    logic [DIV_W-1:0]  w_half;
    logic              w_bit_end;

    assign w_rxd     = r_sync[1];
    assign w_fall    = r_prev & ~w_rxd;
    assign w_half    = DIV_W'((HALF_W'(r_div) + HALF_W'(1)) >> 1);
    assign w_bit_end = (r_cnt == r_div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_rxd};
            r_prev <= w_rxd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= UART_IDLE;
            r_cnt   <= '0;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_div   <= w_div_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_done  <= w_done_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    // With a zero divider the mid-bit offset is 0, so the edge cycle itself is the start sample.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_div_nxt   = r_div;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_done_nxt  = 1'b0;
        w_ferr_nxt  = 1'b0;
        case (r_state)
            UART_IDLE: begin
                if (w_fall) begin
                    w_div_nxt = i_divider;
                    w_bit_nxt = '0;
                    if (i_divider == '0) begin
                        w_state_nxt = UART_DATA;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = UART_START;
                        w_cnt_nxt   = DIV_W'(1);
                    end
                end
            end
            UART_START: begin
                if (r_cnt == w_half) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_rxd ? UART_IDLE : UART_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + DIV_W'(1);
                end
            end
            UART_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rxd, r_shift[BYTE_W-1:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nxt = UART_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + DIV_W'(1);
                end
            end
            UART_STOP: begin
                if (w_bit_end) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = UART_IDLE;
                    w_done_nxt  = w_rxd;
                    w_ferr_nxt  = ~w_rxd;
                end else begin
                    w_cnt_nxt = r_cnt + DIV_W'(1);
                end
            end
            default: w_state_nxt = UART_IDLE;
        endcase
    end

    assign o_rx_byte = r_shift;
    assign o_rx_done = r_done;
    assign o_rx_ferr = r_ferr;

endmodule

// File: rtl/peridot_pfc_uart.sv
// Avalon-MM 8N1 UART on the function side of the PERIDOT pin controller:
// register file, TX frame FSM and function-bus mapping.
module peridot_pfc_uart
    import peridot_pfc_uart_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIVIDER = 16'd867,
    parameter int unsigned RXD_FUNC_BIT    = 1,
    parameter int unsigned TXD_FUNC_BIT    = 0
) (
    input  logic        csi_clk,
    input  logic        rsi_reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        ins_irq,
    input  logic [7:0]  coe_function_din,
    output logic [7:0]  coe_function_dout,
    output logic [7:0]  coe_function_oe
);

    logic [DIV_W-1:0]  r_divider;
    logic [BYTE_W-1:0] r_rx_byte;
    logic              r_rxvalid;
    logic              r_overrun;
    logic              r_ferr;
    logic              r_rxie;
    logic              r_txie;
    logic              r_irq;

    uart_state_e       r_tx_state, w_tx_state_nxt;
    logic [DIV_W-1:0]  r_tx_cnt,   w_tx_cnt_nxt;
    logic [DIV_W-1:0]  r_tx_div,   w_tx_div_nxt;
    logic [BYTE_W-1:0] r_tx_shift, w_tx_shift_nxt;
    logic [2:0]        r_tx_bit,   w_tx_bit_nxt;
    logic              r_txd,      w_txd_nxt;
    logic              r_txready,  w_txready_nxt;

    logic              w_wr_data;
    logic              w_wr_stat;
    logic              w_wr_div;
    logic              w_rd_data;
    logic              w_tx_tick;
    logic [BYTE_W-1:0] w_rx_byte;
    logic              w_rx_done;
    logic              w_rx_ferr;
    logic [BUS_W-1:0]  w_stat;
    logic              w_unused;

    assign w_wr_data = avs_write & (avs_address == REG_DATA);
    assign w_wr_stat = avs_write & (avs_address == REG_STAT);
    assign w_wr_div  = avs_write & (avs_address == REG_DIV);
    assign w_rd_data = avs_read  & (avs_address == REG_DATA);
    assign w_tx_tick = (r_tx_cnt == r_tx_div);
    assign w_unused  = &{1'b0, avs_writedata[31:16], coe_function_din};

    peridot_pfc_uart_rx u_rx (
        .clk       (csi_clk),
        .rst_n     (rsi_reset_n),
        .i_rxd     (coe_function_din[RXD_FUNC_BIT]),
        .i_divider (r_divider),
        .o_rx_byte (w_rx_byte),
        .o_rx_done (w_rx_done),
        .o_rx_ferr (w_rx_ferr)
    );

    // Register file; hardware set beats a same-cycle read clear or W1C.
    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            r_divider <= DEFAULT_DIVIDER;
            r_rx_byte <= '0;
            r_rxvalid <= 1'b0;
            r_overrun <= 1'b0;
            r_ferr    <= 1'b0;
            r_rxie    <= 1'b0;
            r_txie    <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (w_wr_div) begin
                r_divider <= avs_writedata[DIV_W-1:0];
            end
            if (w_wr_stat) begin
                r_rxie <= avs_writedata[STAT_RXIE];
                r_txie <= avs_writedata[STAT_TXIE];
            end
            if (w_rx_done) begin
                r_rx_byte <= w_rx_byte;
            end
            r_rxvalid <= w_rx_done | (r_rxvalid & ~w_rd_data);
            r_overrun <= (w_rx_done & r_rxvalid & ~w_rd_data)
                       | (r_overrun & ~(w_wr_stat & avs_writedata[STAT_OVERRUN]));
            r_ferr    <= w_rx_ferr
                       | (r_ferr & ~(w_wr_stat & avs_writedata[STAT_FERR]));
            r_irq     <= (r_rxie & r_rxvalid) | (r_txie & r_txready);
        end
    end

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            r_tx_state <= UART_IDLE;
            r_tx_cnt   <= '0;
            r_tx_div   <= '0;
            r_tx_shift <= '0;
            r_tx_bit   <= '0;
            r_txd      <= 1'b1;
            r_txready  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_div   <= w_tx_div_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_txd      <= w_txd_nxt;
            r_txready  <= w_txready_nxt;
        end
    end

    // TX frame: divider captured at frame start, each bit held until the counter reaches it.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt;
        w_tx_div_nxt   = r_tx_div;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_bit_nxt   = r_tx_bit;
        w_txd_nxt      = r_txd;
        w_txready_nxt  = r_txready;
        case (r_tx_state)
            UART_IDLE: begin
                if (w_wr_data) begin
                    w_tx_state_nxt = UART_START;
                    w_tx_cnt_nxt   = '0;
                    w_tx_div_nxt   = r_divider;
                    w_tx_shift_nxt = avs_writedata[BYTE_W-1:0];
                    w_tx_bit_nxt   = '0;
                    w_txd_nxt      = 1'b0;
                    w_txready_nxt  = 1'b0;
                end
            end
            UART_START: begin
                if (w_tx_tick) begin
                    w_tx_state_nxt = UART_DATA;
                    w_tx_cnt_nxt   = '0;
                    w_txd_nxt      = r_tx_shift[0];
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + DIV_W'(1);
                end
            end
            UART_DATA: begin
                if (w_tx_tick) begin
                    w_tx_cnt_nxt = '0;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_nxt = UART_STOP;
                        w_txd_nxt      = 1'b1;
                    end else begin
                        w_tx_bit_nxt   = r_tx_bit + 3'd1;
                        w_tx_shift_nxt = {1'b0, r_tx_shift[BYTE_W-1:1]};
                        w_txd_nxt      = r_tx_shift[1];
                    end
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + DIV_W'(1);
                end
            end
            UART_STOP: begin
                if (w_tx_tick) begin
                    w_tx_state_nxt = UART_IDLE;
                    w_tx_cnt_nxt   = '0;
                    w_txready_nxt  = 1'b1;
                end else begin
                    w_tx_cnt_nxt = r_tx_cnt + DIV_W'(1);
                end
            end
            default: w_tx_state_nxt = UART_IDLE;
        endcase
    end

    always_comb begin
        w_stat               = '0;
        w_stat[STAT_TXREADY] = r_txready;
        w_stat[STAT_RXVALID] = r_rxvalid;
        w_stat[STAT_OVERRUN] = r_overrun;
        w_stat[STAT_FERR]    = r_ferr;
        w_stat[STAT_RXIE]    = r_rxie;
        w_stat[STAT_TXIE]    = r_txie;
    end

    always_comb begin
        avs_readdata = '0;
        case (avs_address)
            REG_DATA: avs_readdata = {{(BUS_W-BYTE_W){1'b0}}, r_rx_byte};
            REG_STAT: avs_readdata = w_stat;
            REG_DIV:  avs_readdata = {{(BUS_W-DIV_W){1'b0}}, r_divider};
            default:  avs_readdata = '0;
        endcase
    end

    always_comb begin
        coe_function_dout               = '0;
        coe_function_oe                 = '0;
        coe_function_dout[TXD_FUNC_BIT] = r_txd;
        coe_function_oe[TXD_FUNC_BIT]   = 1'b1;
    end

    assign ins_irq = r_irq;

endmodule
